// File: rtl/reg_file.sv
// 32-entry MIPS general-purpose register file with asynchronous clear,
// hardwired zero register and same-cycle WB-to-ID write-through bypass.
`timescale 1ns/1ps

module reg_file #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned REG_NUM = 32   // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en_1,
    input  logic [ADDR_W-1:0] read_addr_1,
    output logic [DATA_W-1:0] read_data_1,
    input  logic              read_en_2,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] read_data_2
);

    // Entry 0 is cleared on reset and never written, so it always holds zero.
    logic [DATA_W-1:0] r_regs [REG_NUM];

    logic w_wr_valid;
    logic w_byp_1;
    logic w_byp_2;

    // A write is only real when strobed and not aimed at the zero register.
    assign w_wr_valid = write_en && (write_addr != '0);

    // Bypass hits; rule order in the read muxes keeps address 0 out of these.
    assign w_byp_1 = write_en && (write_addr == read_addr_1);
    assign w_byp_2 = write_en && (write_addr == read_addr_2);

    // Register array: async clear of every entry, one WB write per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[write_addr] <= write_data;
        end
    end

    // Port 1 read mux: reset, enable, zero register, bypass, then array.
    always_comb begin
        read_data_1 = '0;
        if (rst || !read_en_1 || (read_addr_1 == '0)) begin
            read_data_1 = '0;
        end else if (w_byp_1) begin
            read_data_1 = write_data;
        end else begin
            read_data_1 = r_regs[read_addr_1];
        end
    end

    // Port 2 read mux: same priority as port 1, fully independent.
    always_comb begin
        read_data_2 = '0;
        if (rst || !read_en_2 || (read_addr_2 == '0)) begin
            read_data_2 = '0;
        end else if (w_byp_2) begin
            read_data_2 = write_data;
        end else begin
            read_data_2 = r_regs[read_addr_2];
        end
    end

endmodule
